regfile_write_arbiter: RTL and testbench

// - Sole owner of the register file's single write port.
// - After reset, sweeps x01..x31 to a known value; the register file has no reset of its own.
// - Then shares the write port between two writeback requesters (req0 = ALU, req1 = load unit).
// - Arbitration is round-robin with valid/ready handshakes, one write per cycle max.
// - Sits between the core's writeback stage and the register file's wr_ena/wr_addr/wr_data.
//

---
 rtl/regfile_write_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_regfile_write_arbiter.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Owns the register file's single write port. After reset it sweeps x01..x31
// to CLEAR_VALUE, because the register file itself has no reset. It then
// shares the port between two writeback requesters (req0 = ALU,
// req1 = load unit). The requesters are arbitrated round-robin with
// valid/ready handshakes, and at most one write is made per cycle.
// The write-port outputs are registered. A write that is accepted in one
// cycle appears on rf_wr_* at the next edge.

module regfile_write_arbiter #(
  parameter bit          CLEAR_ON_RESET = 1'b1,
  parameter logic [31:0] CLEAR_VALUE    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [4:0]  req0_addr,
  input  logic [31:0] req0_data,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [4:0]  req1_addr,
  input  logic [31:0] req1_data,
  output logic        init_done,
  output logic        rf_wr_ena,
  output logic [4:0]  rf_wr_addr,
  output logic [31:0] rf_wr_data
);

  localparam int          NUM_REQ  = 2;
  localparam logic [4:0]  LAST_REG = 5'd31;
  localparam logic [4:0]  FIRST_REG = 5'd1;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  // When the sweep is disabled, the block comes out of reset already serving requests.
  localparam state_t RESET_STATE = CLEAR_ON_RESET ? CLEAR : RUN;
  localparam logic   RESET_INIT  = CLEAR_ON_RESET ? 1'b0 : 1'b1;

  // Architectural state
  state_t      state_reg,      state_next;
  logic [4:0]  clr_cnt_reg,    clr_cnt_next;
  logic        last_grant_reg, last_grant_next;
  logic        init_done_reg,  init_done_next;
  logic        wr_ena_reg,     wr_ena_next;
  logic [4:0]  wr_addr_reg,    wr_addr_next;
  logic [31:0] wr_data_reg,    wr_data_next;

  // Requester ports gathered into arrays so the grant logic is written once.
  logic [NUM_REQ-1:0] req_valid;
  logic [4:0]         req_addr [NUM_REQ];
  logic [31:0]        req_data [NUM_REQ];
  logic [NUM_REQ-1:0] req_ready;

  assign req_valid   = {req1_valid, req0_valid};
  assign req_addr[0] = req0_addr;
  assign req_addr[1] = req1_addr;
  assign req_data[0] = req0_data;
  assign req_data[1] = req1_data;

  // Grant selection
  logic grant_any;
  logic grant_idx;
  logic in_run;

  assign in_run = (state_reg == RUN);

  // Round-robin pick: a lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = 1'b0;
    unique case (req_valid)
      2'b01: begin
        grant_any = 1'b1;
        grant_idx = 1'b0;
      end
      2'b10: begin
        grant_any = 1'b1;
        grant_idx = 1'b1;
      end
      2'b11: begin
        grant_any = 1'b1;
        grant_idx = ~last_grant_reg;
      end
      default: begin
        grant_any = 1'b0;
        grant_idx = 1'b0;
      end
    endcase
  end

  // Per-requester ready. It is forced low during the sweep so that no
  // requester write can interleave with the clear.
  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
      assign req_ready[gi] = in_run && grant_any &&
                             (grant_idx == 1'(gi)) && req_valid[gi];
    end
  endgenerate

  assign req0_ready = req_ready[0];
  assign req1_ready = req_ready[1];

  // Winner's payload
  logic        transfer;
  logic [4:0]  win_addr;
  logic [31:0] win_data;

  assign transfer = |req_ready;
  assign win_addr = req_addr[grant_idx];
  assign win_data = req_data[grant_idx];

  // Next-state logic: the clear sweep, then arbitrated writeback.
  always_comb begin
    state_next      = state_reg;
    clr_cnt_next    = clr_cnt_reg;
    last_grant_next = last_grant_reg;
    init_done_next  = init_done_reg;
    wr_ena_next     = 1'b0;
    wr_addr_next    = wr_addr_reg;
    wr_data_next    = wr_data_reg;

    unique case (state_reg)
      CLEAR: begin
        wr_ena_next  = 1'b1;
        wr_addr_next = clr_cnt_reg;
        wr_data_next = CLEAR_VALUE;
        clr_cnt_next = clr_cnt_reg + 5'd1;
        // init_done rises together with the final x31 write.
        if (clr_cnt_reg == LAST_REG) begin
          state_next     = RUN;
          init_done_next = 1'b1;
        end
      end
      RUN: begin
        if (transfer) begin
          wr_addr_next    = win_addr;
          wr_data_next    = win_data;
          // x00 is hardwired zero: the write is accepted but never issued.
          wr_ena_next     = (win_addr != 5'd0);
          last_grant_next = grant_idx;
        end
      end
      default: begin
        state_next = RESET_STATE;
      end
    endcase
  end

  // State and write-port registers. Reset drops any pending write and restarts the sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= RESET_STATE;
      clr_cnt_reg    <= FIRST_REG;
      last_grant_reg <= 1'b1;
      init_done_reg  <= RESET_INIT;
      wr_ena_reg     <= 1'b0;
      wr_addr_reg    <= 5'd0;
      wr_data_reg    <= 32'd0;
    end else begin
      state_reg      <= state_next;
      clr_cnt_reg    <= clr_cnt_next;
      last_grant_reg <= last_grant_next;
      init_done_reg  <= init_done_next;
      wr_ena_reg     <= wr_ena_next;
      wr_addr_reg    <= wr_addr_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign init_done  = init_done_reg;
  assign rf_wr_ena  = wr_ena_reg;
  assign rf_wr_addr = wr_addr_reg;
  assign rf_wr_data = wr_data_reg;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Scoreboard bench. A reference model predicts the readies for each cycle and
// the registered write-port contents after each edge. Predictions go into a
// queue and are compared one cycle later, when the DUT presents them.

module tb_regfile_write_arbiter;

  localparam logic [31:0] CLR_VAL = 32'h0BAD_F00D;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0;
  logic        req0_ready;
  logic [4:0]  req0_addr = 5'd0;
  logic [31:0] req0_data = 32'd0;
  logic        req1_valid = 1'b0;
  logic        req1_ready;
  logic [4:0]  req1_addr = 5'd0;
  logic [31:0] req1_data = 32'd0;
  logic        init_done;
  logic        rf_wr_ena;
  logic [4:0]  rf_wr_addr;
  logic [31:0] rf_wr_data;

  always #5 clk = ~clk;

  regfile_write_arbiter #(
    .CLEAR_ON_RESET (1'b1),
    .CLEAR_VALUE    (CLR_VAL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .init_done  (init_done),
    .rf_wr_ena  (rf_wr_ena),
    .rf_wr_addr (rf_wr_addr),
    .rf_wr_data (rf_wr_data)
  );

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } req_t;

  typedef struct packed {
    logic        ena;
    logic [4:0]  addr;
    logic [31:0] data;
    logic        init;
  } exp_t;

  req_t q0[$];
  req_t q1[$];
  exp_t exp_q[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  logic        m_run  = 1'b0;
  logic        m_init = 1'b0;
  logic        m_last = 1'b1;
  logic [4:0]  m_cnt  = 5'd1;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic        take0  = 1'b0;
  logic        take1  = 1'b0;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive the pending requests, check the previous edge's
  // result and this cycle's readies, predict the next edge, then advance.
  task automatic cycle();
    exp_t        e;
    logic        v0;
    logic        v1;
    logic        g_any;
    logic        g_idx;
    logic        mena;
    req_t        w;
    v0 = (q0.size() > 0);
    v1 = (q1.size() > 0);
    req0_valid = v0;
    req0_addr  = v0 ? q0[0].addr : 5'd0;
    req0_data  = v0 ? q0[0].data : 32'd0;
    req1_valid = v1;
    req1_addr  = v1 ? q1[0].addr : 5'd0;
    req1_data  = v1 ? q1[0].data : 32'd0;

    @(negedge clk);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_value("rf_wr_ena", 32'(rf_wr_ena), 32'(e.ena));
      check_value("rf_wr_addr", 32'(rf_wr_addr), 32'(e.addr));
      check_value("rf_wr_data", rf_wr_data, e.data);
      check_value("init_done", 32'(init_done), 32'(e.init));
      if (e.ena)
        $display("WR addr=%0d data=%h init_done=%0b", rf_wr_addr, rf_wr_data, init_done);
    end

    take0 = 1'b0;
    take1 = 1'b0;
    mena  = 1'b0;
    if (rst) begin
      m_run  = 1'b0;
      m_init = 1'b0;
      m_last = 1'b1;
      m_cnt  = 5'd1;
      m_addr = 5'd0;
      m_data = 32'd0;
    end else begin
      g_any = v0 | v1;
      g_idx = (v0 && v1) ? ~m_last : v1;
      check_value("req0_ready", 32'(req0_ready), 32'(m_run && v0 && (g_idx == 1'b0)));
      check_value("req1_ready", 32'(req1_ready), 32'(m_run && v1 && (g_idx == 1'b1)));
      if (!m_run) begin
        mena   = 1'b1;
        m_addr = m_cnt;
        m_data = CLR_VAL;
        if (m_cnt == 5'd31) begin
          m_run  = 1'b1;
          m_init = 1'b1;
        end
        m_cnt = m_cnt + 5'd1;
      end else if (g_any) begin
        w      = g_idx ? q1[0] : q0[0];
        m_addr = w.addr;
        m_data = w.data;
        mena   = (w.addr != 5'd0);
        m_last = g_idx;
        take0  = ~g_idx;
        take1  = g_idx;
      end
    end
    exp_q.push_back('{mena, m_addr, m_data, m_init});

    @(posedge clk);
    #1;
    if (take0) q0.delete(0);
    if (take1) q1.delete(0);
  endtask

  initial begin
    // Reset, with a request to x00 already waiting through the whole sweep
    rst = 1'b1;
    repeat (2) cycle();
    rst = 1'b0;
    q1.push_back('{5'd0, 32'h0000_1234});
    repeat (31) cycle();
    // First RUN cycle: the x00 write is accepted and dropped
    cycle();

    // Sustained contention: grants alternate starting with req0
    for (int i = 1; i <= 4; i++) begin
      q0.push_back('{5'(i), 32'h0000_0100 + 32'(i)});
      q1.push_back('{5'(10 + i), 32'h0000_0200 + 32'(i)});
    end
    repeat (9) cycle();

    // Single requester
    q0.push_back('{5'd5, 32'hDEAD_BEEF});
    repeat (2) cycle();

    // Same destination from both requesters
    q0.push_back('{5'd7, 32'hAAAA_AAAA});
    q1.push_back('{5'd7, 32'hBBBB_BBBB});
    repeat (3) cycle();

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      if (q0.size() < 3 && $urandom_range(0, 2) != 0)
        q0.push_back('{5'($urandom_range(0, 31)), 32'($urandom)});
      if (q1.size() < 3 && $urandom_range(0, 2) != 0)
        q1.push_back('{5'($urandom_range(0, 31)), 32'($urandom)});
      cycle();
    end

    // Reset mid-RUN, then again part-way through the sweep
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (10) cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (33) cycle();
    repeat (20) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
